qar_dmem_ctrl: RTL and testbench

Synthesizable data-memory controller on the external memory port of qar_core (USE_INTERNAL_MEM=0). It accepts single-word load/store requests over the core's mem_valid/mem_ready handshake and serves them from an internal word RAM. Wait states are programmable (fixed or pseudo-random stress mode), and illegal accesses are reported. It replaces the behavioural bench memory in FPGA builds, and regressions run against it.

---
 rtl/qar_dmem_ctrl_if.sv | 19 +
 rtl/qar_dmem_ctrl.sv | 151 +++++++++++++++
 tb/tb_qar_dmem_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/qar_dmem_ctrl_if.sv
// rtl/qar_dmem_ctrl_if.sv - core-side load/store request bus for the data-memory controller
interface qar_dmem_ctrl_if;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/qar_dmem_ctrl.sv
// rtl/qar_dmem_ctrl.sv - word-RAM data-memory controller with programmable wait states and error reporting
module qar_dmem_ctrl #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WAIT_W    = 2,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst_n,
    qar_dmem_ctrl_if.slave    bus,
    input  logic              cfg_rand,
    input  logic [WAIT_W-1:0] cfg_wait,
    output logic              busy,
    output logic              err_pulse,
    output logic [7:0]        err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    // Where mem_rdata comes from: cleared by reset, the RAM read register, or the error constant
    typedef enum logic [1:0] {RD_ZERO, RD_RAM, RD_ERR} rsel_t;

    state_t            state_q, state_d;
    rsel_t             rsel_q, rsel_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              err_pulse_q, err_pulse_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [15:0]       lfsr_q, lfsr_d;

    logic [32:0]       off;
    logic [AW-1:0]     idx;
    logic              acc_err;
    logic              lfsr_fb;
    logic              ram_en;
    logic              ram_wr;
    logic [31:0]       ram_dout;
    logic [31:0]       mem [DEPTH];

    // Decode the latched address: offset from base, word index and legality
    always_comb begin
        off     = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        idx     = off[AW+1:2];
        acc_err = (addr_q[1:0] != 2'b00) || off[32] || (off >= SPAN);
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end

    // Next-state and datapath: accept in IDLE, count down in WAIT, guard cycle in RESP
    always_comb begin
        state_d     = state_q;
        rsel_d      = rsel_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ready_d     = 1'b0;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        lfsr_d      = lfsr_q;
        ram_en      = 1'b0;
        ram_wr      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_valid) begin
                    we_d    = bus.mem_we;
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    cnt_d   = cfg_rand ? lfsr_q[WAIT_W-1:0] : cfg_wait;
                    lfsr_d  = {lfsr_q[14:0], lfsr_fb};
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ready_d = 1'b1;
                    state_d = S_RESP;
                    if (acc_err) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                        if (!we_q) rsel_d = RD_ERR;
                    end else begin
                        ram_en = 1'b1;
                        ram_wr = we_q;
                        if (!we_q) rsel_d = RD_RAM;
                    end
                end
            end
            S_RESP: begin
                // valid is deliberately ignored here so a held request is not taken twice
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rsel_q      <= RD_ZERO;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            state_q     <= state_d;
            rsel_q      <= rsel_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            lfsr_q      <= lfsr_d;
        end
    end

    // Single-port synchronous RAM; reset suppresses an access that lands on the reset edge
    always_ff @(posedge clk) begin
        if (rst_n && ram_en) begin
            if (ram_wr) mem[idx] <= wdata_q;
            else        ram_dout <= mem[idx];
        end
    end

    // Output mux: the read register is only exposed after a successful load
    always_comb begin
        case (rsel_q)
            RD_RAM:  bus.mem_rdata = ram_dout;
            RD_ERR:  bus.mem_rdata = ERR_RDATA;
            default: bus.mem_rdata = 32'h0;
        endcase
    end

    assign bus.mem_ready = ready_q;
    assign busy          = (state_q != S_IDLE);
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_count_q;
endmodule

// File: tb/tb_qar_dmem_ctrl.sv
// tb/tb_qar_dmem_ctrl.sv - directed and scoreboard bench for qar_dmem_ctrl
module tb_qar_dmem_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_rand;
    logic [1:0] cfg_wait;
    logic       busy;
    logic       err_pulse;
    logic [7:0] err_count;

    qar_dmem_ctrl_if bus();

    qar_dmem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .cfg_rand  (cfg_rand),
        .cfg_wait  (cfg_wait),
        .busy      (busy),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] lfsr_m;
    int          last_cnt;
    logic [31:0] sb [16];
    logic        seen [4];
    vec_t        vecs [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Issue one request from an IDLE controller; called #1 after a posedge
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err);
        int   exp_cnt;
        int   edges;
        logic got;
        exp_cnt  = cfg_rand ? int'(lfsr_m[1:0]) : int'(cfg_wait);
        last_cnt = exp_cnt;
        lfsr_m   = lfsr_next(lfsr_m);
        bus.mem_we    = we;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_valid = 1'b1;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (bus.mem_ready) got = 1'b1;
            else chk("busy_wait", busy, 1'b1);
        end
        bus.mem_valid = 1'b0;
        chk("ready_seen", got, 1'b1);
        if (got) begin
            chk("latency", edges, exp_cnt + 2);
            chk("err_pulse", err_pulse, exp_err);
            chk("busy_resp", busy, 1'b1);
            if (!we) chk("rdata", bus.mem_rdata, exp_rd);
            @(posedge clk); #1;
            chk("ready_width", bus.mem_ready, 1'b0);
            chk("err_pulse_width", err_pulse, 1'b0);
            chk("busy_idle", busy, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'hCAFE_0001, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'h0000_1111, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 32'h0000_03FC, 32'hFFFF_0000, 32'h0,         1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0400, 32'hBAD0_0000, 32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0042, 32'hBAD0_0001, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0402, 32'h0,         32'hDEAD_BEEF, 1'b1};
        vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_0001, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,         32'hFFFF_0000, 1'b0};

        bus.mem_valid = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        cfg_rand      = 1'b0;
        cfg_wait      = 2'd0;
        rst_n         = 1'b0;
        lfsr_m        = 16'hACE1;
        for (int i = 0; i < 4; i++) seen[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bus.mem_ready, 1'b0);
        chk("rst_rdata", bus.mem_rdata, 32'h0);
        chk("rst_err_pulse", err_pulse, 1'b0);
        chk("rst_err_count", err_count, 8'd0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed wait 0 vectors, including boundary word and the three error cases
        for (int i = 0; i < 11; i++)
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err);
        chk("err_count_3", err_count, 8'd3);

        // Fixed wait 3 load
        cfg_wait = 2'd3;
        do_req(1'b0, 32'h0000_0000, 32'h0, 32'hCAFE_0001, 1'b0);
        cfg_wait = 2'd0;

        // Saturation of the error counter
        for (int i = 0; i < 260; i++)
            do_req(1'b0, 32'h0000_0402, 32'h0, 32'hDEAD_BEEF, 1'b1);
        chk("err_count_sat", err_count, 8'd255);

        // Valid held through RESP is not re-accepted
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h0000_0080;
        bus.mem_wdata = 32'h5A5A_0080;
        bus.mem_valid = 1'b1;
        lfsr_m        = lfsr_next(lfsr_m);
        @(posedge clk); #1;
        chk("hold_accept_busy", busy, 1'b1);
        chk("hold_no_ready_yet", bus.mem_ready, 1'b0);
        @(posedge clk); #1;
        chk("hold_ready", bus.mem_ready, 1'b1);
        @(posedge clk); #1;
        chk("hold_resp_ready", bus.mem_ready, 1'b0);
        chk("hold_resp_not_taken", busy, 1'b0);
        bus.mem_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold_idle_busy", busy, 1'b0);
        chk("hold_idle_ready", bus.mem_ready, 1'b0);
        do_req(1'b0, 32'h0000_0080, 32'h0, 32'h5A5A_0080, 1'b0);

        // Reset one cycle after acceptance of a wait-3 store
        cfg_wait      = 2'd3;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h0000_0010;
        bus.mem_wdata = 32'h0000_2222;
        bus.mem_valid = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_accepted", busy, 1'b1);
        bus.mem_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_ready", bus.mem_ready, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_err_pulse", err_pulse, 1'b0);
        chk("rstmid_err_count", err_count, 8'd0);
        chk("rstmid_rdata", bus.mem_rdata, 32'h0);
        lfsr_m = 16'hACE1;
        rst_n  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rstmid_no_ready", bus.mem_ready, 1'b0);
        end
        cfg_wait = 2'd0;
        do_req(1'b0, 32'h0000_0010, 32'h0, 32'h0000_1111, 1'b0);

        // Random wait mode against a scoreboard; latency follows the bench LFSR
        cfg_rand = 1'b1;
        for (int w = 0; w < 16; w++) begin
            sb[w] = $urandom;
            do_req(1'b1, 32'(w) << 2, sb[w], 32'h0, 1'b0);
            seen[last_cnt] = 1'b1;
        end
        for (int k = 0; k < 64; k++) begin
            int w;
            w = $urandom_range(0, 15);
            if (k % 2 == 0) begin
                sb[w] = $urandom;
                do_req(1'b1, 32'(w) << 2, sb[w], 32'h0, 1'b0);
            end else begin
                do_req(1'b0, 32'(w) << 2, 32'h0, sb[w], 1'b0);
            end
            seen[last_cnt] = 1'b1;
        end
        for (int i = 0; i < 4; i++) chk("rand_wait_coverage", seen[i], 1'b1);
        chk("rand_no_errors", err_count, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
